// File: rtl/gate_exerciser_pkg.sv
// Shared types and constants for the gate exerciser family.
// State encoding, vector count and common truth tables.
package gate_lab_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int VEC_COUNT = 4;

  localparam logic [1:0] LAST_VEC =
    2'(VEC_COUNT - 1);

  localparam logic [3:0] TRUTH_NOR  = 4'b0001;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;

  // One-hot select of the fail_mask bit for a vector.
  function automatic logic [3:0] vec_bit(
    input logic [1:0] v
  );
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/gate_exerciser_if.sv
// Bundle between the exerciser and its gate/host side.
// master: exerciser (drives a/b, status); slave: gate + host.
interface gate_exerciser_if;
  import gate_lab_pkg::*;

  logic                 start;
  logic                 dut_c;
  logic                 a_out;
  logic                 b_out;
  logic [1:0]           vec_idx;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [VEC_COUNT-1:0] fail_mask;

  modport master (
    input  start,
    input  dut_c,
    output a_out,
    output b_out,
    output vec_idx,
    output busy,
    output done,
    output pass,
    output fail_mask
  );

  modport slave (
    output start,
    output dut_c,
    input  a_out,
    input  b_out,
    input  vec_idx,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask
  );

endinterface

// File: rtl/hold_timer.sv
// Window timer: counts LIMIT cycles while en, reloads itself.
// Ports: clk, rst_n, clr (sync reload), en, tc (last-cycle pulse).
module hold_timer #(
  parameter int LIMIT = 100,
  parameter bit UP    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  localparam logic [W-1:0] LAST  = W'(LIMIT - 1);
  localparam logic [W-1:0] ZERO  = {W{1'b0}};
  localparam logic [W-1:0] FIRST = UP ? ZERO : LAST;
  localparam logic [W-1:0] TERM  = UP ? LAST : ZERO;

  logic [W-1:0] hold_cnt;

  // Terminal count doubles as the auto-reload request,
  // so the count never wraps inside a window.
  assign tc = en & (hold_cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= FIRST;
    end else if (clr || tc) begin
      hold_cnt <= FIRST;
    end else if (en) begin
      if (UP) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_exerciser.sv
// Steps a 2-input gate through 00,01,10,11 and checks its output.
// Ports: clk, rst_n, bus (start/dut_c in; a/b, vec_idx, status out).
module gate_exerciser
  import gate_lab_pkg::*;
#(
  parameter int         HOLD_CYCLES = 100,
  parameter logic [3:0] TRUTH       = TRUTH_NOR
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_exerciser_if.master  bus
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] vec_q;
  logic [1:0] vec_d;
  logic       busy_q;
  logic       busy_d;
  logic       done_q;
  logic       done_d;
  logic       pass_q;
  logic       pass_d;
  logic [3:0] mask_q;
  logic [3:0] mask_d;

  logic       win_end;
  logic       mismatch;
  logic [3:0] mask_eval;

  hold_timer #(
    .LIMIT (HOLD_CYCLES),
    .UP    (1'b1)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != RUN),
    .en    (state_q == RUN),
    .tc    (win_end)
  );

  // The last vector's mismatch has to reach pass on the
  // same edge, so the merged mask is formed up front.
  assign mismatch  = bus.dut_c ^ TRUTH[vec_q];
  assign mask_eval = mask_q |
    (mismatch ? vec_bit(vec_q) : 4'b0000);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        vec_d  = 2'd0;
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mask_d  = 4'b0000;
        end
      end
      RUN: begin
        if (win_end) begin
          mask_d = mask_eval;
          if (vec_q == LAST_VEC) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            vec_d   = 2'd0;
            pass_d  = ~|mask_eval;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vec_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.a_out     = vec_q[1];
  assign bus.b_out     = vec_q[0];
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser with an expected-result queue.
// Two instances: H=4 NOR truth table, H=2 NAND truth table.
module tb_gate_exerciser;
  import gate_lab_pkg::*;

  typedef enum int {
    G_NOR, G_AND, G_NAND, G_ZERO, G_ONE
  } gate_e;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  sel;
  gate_e g4;
  gate_e g2;
  int    checks = 0;
  int    errors = 0;

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  gate_exerciser_if bus4 ();
  gate_exerciser_if bus2 ();

  gate_exerciser #(
    .HOLD_CYCLES (4),
    .TRUTH       (TRUTH_NOR)
  ) u_h4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  gate_exerciser #(
    .HOLD_CYCLES (2),
    .TRUTH       (TRUTH_NAND)
  ) u_h2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  function automatic logic gate_out(
    input gate_e g,
    input logic  a,
    input logic  b
  );
    case (g)
      G_NOR:   return ~(a | b);
      G_AND:   return a & b;
      G_NAND:  return ~(a & b);
      G_ZERO:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign bus4.dut_c =
    gate_out(g4, bus4.a_out, bus4.b_out);
  assign bus2.dut_c =
    gate_out(g2, bus2.a_out, bus2.b_out);

  logic       m_a;
  logic       m_b;
  logic [1:0] m_vec;
  logic       m_busy;
  logic       m_done;
  logic       m_pass;
  logic [3:0] m_mask;

  always_comb begin
    m_a    = sel ? bus2.a_out     : bus4.a_out;
    m_b    = sel ? bus2.b_out     : bus4.b_out;
    m_vec  = sel ? bus2.vec_idx   : bus4.vec_idx;
    m_busy = sel ? bus2.busy      : bus4.busy;
    m_done = sel ? bus2.done      : bus4.done;
    m_pass = sel ? bus2.pass      : bus4.pass;
    m_mask = sel ? bus2.fail_mask : bus4.fail_mask;
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) bus2.start = v;
    else     bus4.start = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},    8'(m_a),    8'h00);
    chk({tag, "_b"},    8'(m_b),    8'h00);
    chk({tag, "_vec"},  8'(m_vec),  8'h00);
    chk({tag, "_busy"}, 8'(m_busy), 8'h00);
    chk({tag, "_done"}, 8'(m_done), 8'h00);
    chk({tag, "_pass"}, 8'(m_pass), 8'h00);
    chk({tag, "_mask"}, 8'(m_mask), 8'h00);
  endtask

  task automatic kick(input logic [3:0] e);
    @(negedge clk);
    exp_q.push_back(e);
    drive_start(1'b1);
    @(posedge clk);
    #1;
    drive_start(1'b0);
  endtask

  // Called just after the accepted start edge; ends on the
  // negedge where done must be high.
  task automatic track_run(input int h, input bit poke);
    logic [3:0] e;
    for (int j = 0; j <= 4 * h; j++) begin
      @(negedge clk);
      if (poke) drive_start((j == 3) || (j == 6));
      if (j < 4 * h) begin
        chk("run_vec",  8'(m_vec),      8'(j / h));
        chk("run_ab",   8'({m_a, m_b}), 8'(j / h));
        chk("run_busy", 8'(m_busy),     8'h01);
        chk("run_done", 8'(m_done),     8'h00);
        if (j == 0) begin
          chk("new_mask", 8'(m_mask), 8'h00);
          chk("new_pass", 8'(m_pass), 8'h00);
        end
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard empty at done");
      end else begin
        e = exp_q.pop_front();
        chk("end_done", 8'(m_done), 8'h01);
        chk("end_busy", 8'(m_busy), 8'h00);
        chk("end_vec",  8'(m_vec),  8'h00);
        chk("end_ab",   8'({m_a, m_b}), 8'h00);
        chk("end_mask", 8'(m_mask), 8'(e));
        chk("end_pass", 8'(m_pass), 8'(e == 4'b0000));
      end
    end
  endtask

  task automatic after_done(input logic [3:0] e);
    @(negedge clk);
    chk("post_done", 8'(m_done), 8'h00);
    chk("post_busy", 8'(m_busy), 8'h00);
    chk("post_mask", 8'(m_mask), 8'(e));
    chk("post_pass", 8'(m_pass), 8'(e == 4'b0000));
  endtask

  initial begin
    sel        = 1'b0;
    g4         = G_NOR;
    g2         = G_NAND;
    bus4.start = 1'b0;
    bus2.start = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;

    // NOR gate against NOR table
    kick(4'b0000);
    track_run(4, 1'b0);
    after_done(4'b0000);

    // AND gate against NOR table
    g4 = G_AND;
    kick(4'b1001);
    track_run(4, 1'b0);
    after_done(4'b1001);

    // stuck-at outputs
    g4 = G_ZERO;
    kick(4'b0001);
    track_run(4, 1'b0);
    after_done(4'b0001);
    g4 = G_ONE;
    kick(4'b1110);
    track_run(4, 1'b0);
    after_done(4'b1110);

    // start pulses mid-run and during FINISH
    g4 = G_NOR;
    kick(4'b0000);
    track_run(4, 1'b1);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    chk("fin_done", 8'(m_done), 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 8'(m_busy), 8'h00);
      chk("idle_ab", 8'({m_a, m_b}), 8'h00);
    end

    // start held high: three back-to-back runs
    g4 = G_ONE;
    @(negedge clk);
    exp_q.push_back(4'b1110);
    drive_start(1'b1);
    @(posedge clk);
    track_run(4, 1'b0);
    g4 = G_NOR;
    exp_q.push_back(4'b0000);
    @(negedge clk);
    chk("gap1_busy", 8'(m_busy), 8'h00);
    chk("gap1_done", 8'(m_done), 8'h00);
    @(posedge clk);
    track_run(4, 1'b0);
    g4 = G_ZERO;
    exp_q.push_back(4'b0001);
    @(negedge clk);
    chk("gap2_busy", 8'(m_busy), 8'h00);
    chk("gap2_done", 8'(m_done), 8'h00);
    @(posedge clk);
    track_run(4, 1'b0);
    drive_start(1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("held_end_busy", 8'(m_busy), 8'h00);
    end

    // asynchronous reset while vector 2 is applied
    g4 = G_NOR;
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk);
    #1;
    drive_start(1'b0);
    repeat (9) @(negedge clk);
    chk("pre_rst_vec", 8'(m_vec), 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rel_busy", 8'(m_busy), 8'h00);
      chk("rel_ab", 8'({m_a, m_b}), 8'h00);
    end

    // H=2, NAND table with NAND gate
    sel = 1'b1;
    kick(4'b0000);
    track_run(2, 1'b0);
    after_done(4'b0000);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard left %0d entries",
               exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
